// File: rtl/mem_line_pkg.sv
// Shared types and constants for the mem_line_xfer line-transfer controller.
package mem_line_pkg;

  localparam int WORDS_DEFAULT  = 16;
  localparam int DATA_W_DEFAULT = 32;
  localparam int LINE_BYTES     = WORDS_DEFAULT * DATA_W_DEFAULT / 8;
  localparam int OFFSET_BITS    = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    NOP   = 2'b00,
    READ  = 2'b01,
    RSVD  = 2'b10,
    WRITE = 2'b11
  } mem_op_t;

  typedef enum logic [2:0] {
    IDLE,
    R_REQ,
    R_WAIT,
    R_STREAM,
    W_ARM,
    W_FILL,
    W_REQ,
    DONE
  } xfer_state_t;

  // Byte-offset bits below a line boundary for a given geometry.
  function automatic int offset_bits(input int words, input int data_w);
    return $clog2(words * data_w / 8);
  endfunction

endpackage

// File: rtl/mem_line_buf.sv
// Line buffer: WORDS x DATA_W storage with parallel line load, indexed word
// write/read and a flattened line view (word i at bits [i*DATA_W +: DATA_W]).
module mem_line_buf
  import mem_line_pkg::*;
#(
  parameter int WORDS  = WORDS_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [WORDS*DATA_W-1:0] line_i,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [DATA_W-1:0]       rdata_o,
  output logic [WORDS*DATA_W-1:0] line_o
);

  logic [WORDS-1:0][DATA_W-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = line_i;
    end else if (we_i) begin
      line_d[idx_i] = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign rdata_o = line_q[idx_i];
  assign line_o  = line_q;

endmodule

// File: rtl/mem_line_xfer.sv
// Line-transfer controller between the cpu word bus and a line-wide memory port.
// Optional memory watchdog enabled by defining MEM_LINE_XFER_TIMEOUT_EN.
module mem_line_xfer
  import mem_line_pkg::*;
#(
  parameter int WORDS          = WORDS_DEFAULT,
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              op,
  input  logic [ADDR_W-1:0]       io_address,
  input  logic [DATA_W-1:0]       common_data_bus_out,
  output logic [DATA_W-1:0]       common_data_bus_in,
  output logic                    rd_valid,
  output logic                    tx_done,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [WORDS*DATA_W-1:0] mem_wdata,
  input  logic                    mem_rvalid,
  input  logic [WORDS*DATA_W-1:0] mem_rdata,
  output logic                    xfer_err
);

  localparam int CNT_W = $clog2(WORDS);
  localparam int OFF   = offset_bits(WORDS, DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  xfer_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              buf_load, buf_we;
  logic [DATA_W-1:0] buf_rdata;
  logic              timed_out;

  mem_line_buf #(
    .WORDS  (WORDS),
    .DATA_W (DATA_W),
    .IDX_W  (CNT_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .line_i  (mem_rdata),
    .we_i    (buf_we),
    .idx_i   (cnt_q),
    .wdata_i (common_data_bus_out),
    .rdata_o (buf_rdata),
    .line_o  (mem_wdata)
  );

`ifdef MEM_LINE_XFER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q;
  logic             tmr_run;

  assign tmr_run   = (state_q == R_REQ) || (state_q == R_WAIT) || (state_q == W_REQ);
  assign timed_out = tmr_run && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || (state_d != state_q) || !tmr_run) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    buf_load      = 1'b0;
    buf_we        = 1'b0;
    rd_valid      = 1'b0;
    tx_done       = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    xfer_err      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_op_t'(op) == READ || mem_op_t'(op) == WRITE) begin
          addr_d           = io_address;
          addr_d[OFF-1:0]  = '0;
          state_d          = (mem_op_t'(op) == READ) ? R_REQ : W_ARM;
        end
      end
      R_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = R_WAIT;
      end
      R_WAIT: begin
        if (mem_rvalid) begin
          buf_load = 1'b1;
          cnt_d    = '0;
          state_d  = R_STREAM;
        end
      end
      R_STREAM: begin
        rd_valid = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end
      end
      W_ARM: state_d = W_FILL;
      W_FILL: begin
        buf_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = W_REQ;
      end
      W_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        if (mem_req_ready) state_d = DONE;
      end
      DONE: begin
        tx_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog expiry overrides the request/wait handshake of the current cycle.
    if (timed_out) begin
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      buf_load      = 1'b0;
      tx_done       = 1'b1;
      xfer_err      = 1'b1;
      state_d       = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_req_addr       = addr_q;
  assign common_data_bus_in = rd_valid ? buf_rdata : '0;

endmodule

// File: doc/mem_line_xfer.md
Name: mem_line_xfer

Overview:
- Line-transfer memory controller directly downstream of the cpu loopback stage.
- Accepts the cpu's op/io_address/data-bus requests and moves one 16×32-bit line to or from a line-wide memory port.
- Reads: fetches a line, then streams it to the cpu one word per cycle with rd_valid, ending with tx_done.
- Writes: collects 16 words from the cpu data bus, then issues one line write.

Parameters:
- WORDS, 16, words per line; must be a power of two.
- DATA_W, 32, cpu data bus width.
- ADDR_W, 64, address width.
- TIMEOUT_CYCLES, 1024, memory response watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- op  in  2  cpu request: 00 NOP, 01 READ, 10 reserved (treated as NOP), 11 WRITE.
- io_address  in  ADDR_W  line address; low log2(WORDS*DATA_W/8) bits forced to 0 on capture.
- common_data_bus_out  in  DATA_W  write data from the cpu.
- common_data_bus_in  out  DATA_W  read data to the cpu.
- rd_valid  out  1  common_data_bus_in holds a valid read word.
- tx_done  out  1  one-cycle pulse: transfer complete.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we  out  1  1 = write line, 0 = read line.
- mem_req_addr  out  ADDR_W  aligned line address.
- mem_wdata  out  WORDS*DATA_W  write line; word i at bits [i*DATA_W +: DATA_W].
- mem_rvalid  in  1  mem_rdata is valid (one-cycle pulse).
- mem_rdata  in  WORDS*DATA_W  read line, same word packing as mem_wdata.
- xfer_err  out  1  one-cycle timeout error pulse; tied 0 when the optional feature is off.

Behaviour:
- Reset: sync on rst; state IDLE. All outputs 0, including common_data_bus_in, mem_wdata and mem_req_addr. Word counter 0, line buffer cleared.
- rst during any state aborts the transfer: no tx_done, no further mem_req_valid.
- op and io_address are sampled only in IDLE; changes mid-transfer are ignored.
- State machine: IDLE, R_REQ, R_WAIT, R_STREAM, W_ARM, W_FILL, W_REQ, DONE.
- IDLE, op=01: latch aligned address, go to R_REQ.
- IDLE, op=11: latch aligned address, go to W_ARM.
- IDLE, other op: stay in IDLE.
- R_REQ: mem_req_valid=1, mem_req_we=0. Hold valid and address stable until mem_req_ready; on the handshake go to R_WAIT.
- R_WAIT: on mem_rvalid, capture mem_rdata into the line buffer, set counter 0, go to R_STREAM.
- R_STREAM: rd_valid=1 and common_data_bus_in=word[counter] on each of WORDS consecutive cycles, words 0..WORDS-1.
  - tx_done=1 in the same cycle as the last word.
  - Then return to IDLE. There is no DONE cycle on reads.
- W_ARM: one bubble cycle with no capture. The cpu presents word 0 for two cycles; the first is skipped here.
- W_FILL: sample common_data_bus_out into word[counter] every cycle for WORDS cycles; go to W_REQ after word WORDS-1.
- W_REQ: mem_req_valid=1, mem_req_we=1, mem_wdata=line buffer. Hold until mem_req_ready, then go to DONE.
- DONE: tx_done=1 for one cycle, then IDLE. A cpu still driving op=11 starts a new write on the next IDLE cycle.
- Back-to-back: minimum one IDLE cycle between transfers.
- Counter: log2(WORDS) bits, wraps to 0 after WORDS-1.
- mem_rvalid outside R_WAIT: ignored.
- mem_req_ready outside the REQ states: ignored.
- Minimum read latency, op=01 sampled to first rd_valid: 3 cycles with ready and rvalid immediate.

Optional Feature:
- MEM_LINE_XFER_TIMEOUT_EN defined:
  - A cycle counter runs in R_REQ, R_WAIT and W_REQ.
  - On reaching TIMEOUT_CYCLES: pulse xfer_err and tx_done together for one cycle, drop mem_req_valid, return to IDLE.
  - rd_valid is never asserted for an aborted read.
  - The counter clears on every state change.
- Undefined: no counter logic; xfer_err is constant 0; the controller waits indefinitely.

Decomposition:
- Package mem_line_pkg holds:
  - mem_op_t enum: NOP, READ, RSVD, WRITE.
  - xfer_state_t enum.
  - WORDS_DEFAULT, LINE_BYTES and OFFSET_BITS constants.
- Sub-module mem_line_buf: WORDS×DATA_W storage with a parallel line load, single-word indexed write and read, and a flattened line output.

Test Plan:
- Read, ready and rvalid immediate. Stimulus: op=01, addr=0x47, mem_rdata words = 0xA0+i. Required: mem_req_addr=0x40, we=0; rd_valid for 16 cycles carrying 0xA0..0xAF; tx_done with 0xAF; back to IDLE.
- Write. Stimulus: op=11, addr=0x400; cpu holds 0x11 for two cycles, then drives 0x12..0x20. Required: mem_wdata words 0x11..0x20; mem_req_we=1, addr=0x400; tx_done one cycle after mem_req_ready.
- Backpressure. Stimulus: mem_req_ready low 5 cycles, rvalid after 7 more. Required: mem_req_valid and addr stable throughout; no rd_valid before rvalid; stream then identical to the first scenario.
- Reset mid-transfer. Stimulus: rst pulsed at R_STREAM word 6, op=00 afterwards. Required: next cycle all outputs 0; no tx_done; IDLE; next read completes normally.
- Ignored inputs. Stimulus: op=10 in IDLE; op toggled to 01 during W_FILL; stray mem_rvalid in IDLE. Required: no memory request from op=10; write completes unchanged; stray rvalid ignored.
- Timeout (MEM_LINE_XFER_TIMEOUT_EN, TIMEOUT_CYCLES=8). Stimulus: read with mem_req_ready held 0. Required: xfer_err and tx_done pulse together on cycle 8; mem_req_valid drops; no rd_valid.
